// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtraction controller.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter must index 0..width-1; keep at least one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor: d = x - y - c, nb = borrow out. Purely combinational.
module fs_bit_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic c_i,
  output logic d_o,
  output logic nb_o
);

  assign d_o  = x_i ^ y_i ^ c_i;
  assign nb_o = (~x_i & y_i) | (~(x_i ^ y_i) & c_i);

endmodule

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller around a single fs_bit_cell.
// Optional zero/neg result flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtract_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sb_q, res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               br_q;
  logic               accept, last_bit;
  logic               cell_d, cell_nb;

  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  fs_bit_cell u_cell (
    .x_i  (sa_q[0]),
    .y_i  (sb_q[0]),
    .c_i  (br_q),
    .d_o  (cell_d),
    .nb_o (cell_nb)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: a default assignment before the case keeps this block latch-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= '0;
      sb_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
      br_q  <= 1'b0;
    end else if (accept) begin
      sa_q  <= a;
      sb_q  <= b;
      br_q  <= bin;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
      sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
      res_q <= {cell_d, res_q[WIDTH-1:1]};
      br_q  <= cell_nb;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign diff = res_q;
  assign bout = br_q;

`ifdef SERIAL_SUB_FLAGS_EN
  // Sticky "some difference bit was 1" avoids a WIDTH-wide zero compare.
  logic any_one_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                any_one_q <= 1'b0;
    else if (accept)           any_one_q <= 1'b0;
    else if (state_q == RUN)   any_one_q <= any_one_q | cell_d;
  end

  assign zero = out_valid & ~any_one_q;
  assign neg  = res_q[WIDTH-1];
`endif

endmodule
